// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS-subset datapath. It supports R, lw, sw, beq, addi and j.
// Define PERF_CNT_EN to add the instr_cnt/stall_cnt performance counters.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       ZF,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemToWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal,
  output logic [3:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_WB_R  = 4'd7,
    S_EXEC_I = 4'd8,  S_WB_I   = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       in_fetch;
    logic       in_decode;
    logic       in_branch;
    logic       in_jump;
  } ctrl_t;

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.in_fetch = 1'b1; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.in_decode = 1'b1; end
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = 3'b010; end
      S_WB_R:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_EXEC_I: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_WB_I:   c.reg_write = 1'b1;
      S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.in_branch = 1'b1; end
      S_JUMP:   begin c.pc_src = 2'b10; c.in_jump = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t st, nxt;
  ctrl_t  ctl;
  logic   is_lw;
  logic   op_legal;

  assign op_legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_comb begin
    nxt = st;
    case (st)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXEC_R;
          OP_ADDI:      nxt = S_EXEC_I;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      default:  nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so the outputs are glitch-free flops.
  // The reset value matches FETCH so the outputs are valid as soon as reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= S_FETCH;
      ctl   <= decode(S_FETCH);
      is_lw <= 1'b0;
    end else begin
      st  <= nxt;
      ctl <= decode(nxt);
      // op is only meaningful in DECODE, so latch the lw/sw choice for MEMADR.
      if (st == S_DECODE) is_lw <= (op == OP_LW);
    end
  end

  assign PCWrite    = ~reset & ((ctl.in_fetch & mem_ready) | (ctl.in_branch & ZF) | ctl.in_jump);
  assign IRWrite    = ~reset & ctl.in_fetch & mem_ready;
  assign MemRead    = ~reset & ctl.mem_read;
  assign MemToWrite = ~reset & ctl.mem_write;
  assign IorD       = ~reset & ctl.iord;
  assign RegWrite   = ~reset & ctl.reg_write;
  assign RegDst     = ~reset & ctl.reg_dst;
  assign MemToReg   = ~reset & ctl.mem_to_reg;
  assign ALUSrcA    = ~reset & ctl.alu_src_a;
  assign ALUSrcB    = reset ? 2'b00 : ctl.alu_src_b;
  assign ALUOp      = reset ? 3'b000 : ctl.alu_op;
  assign PCSrc      = reset ? 2'b00 : ctl.pc_src;
  assign illegal    = ~reset & ctl.in_decode & ~op_legal;
  assign state      = st;

`ifdef PERF_CNT_EN
  logic stalled;
  assign stalled = ((st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR)) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (st == S_FETCH && mem_ready) instr_cnt <= instr_cnt + 1'b1;
      if (stalled)                    stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. A reference model builds the expected state walk of each instruction from opcode and wait counts.
// It then checks every cycle against the per-state control table.
module tb_multicycle_control_fsm;
  logic       clk, reset, ZF, mem_ready;
  logic [5:0] op;
  logic       PCWrite, IRWrite, MemRead, MemToWrite, IorD, RegWrite, RegDst, MemToReg, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .ZF(ZF), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemToWrite(MemToWrite),
    .IorD(IorD), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal(illegal), .state(state)
`ifdef PERF_CNT_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int instr_m = 0;
  int stall_m = 0;
  int st_q[$];
  bit mr_q[$];

  logic [13:0] moore;
  logic [17:0] outs;
  assign moore = {MemRead, MemToWrite, IorD, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc};
  assign outs  = {PCWrite, IRWrite, moore, illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Per-state control table: {MemRead,MemToWrite,IorD,RegWrite,RegDst,MemToReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  function automatic logic [13:0] exp_moore(int s);
    logic mr = 0, mw = 0, iord = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
    logic [1:0] sb = 0, pcs = 0;
    logic [2:0] ao = 0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; sb = 2'b10; end
      9:  rw = 1;
      10: begin sa = 1; ao = 3'b001; pcs = 2'b01; end
      11: pcs = 2'b10;
      default: ;
    endcase
    return {mr, mw, iord, rw, rd, m2r, sa, sb, ao, pcs};
  endfunction

  function automatic bit legal(logic [5:0] o);
    return o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_ADDI || o == OP_J;
  endfunction

  task automatic push(int s);
    st_q.push_back(s);
    mr_q.push_back(1'($urandom));
  endtask

  task automatic push_wait(int s, int waits);
    for (int k = 0; k < waits; k++) begin st_q.push_back(s); mr_q.push_back(1'b0); end
    st_q.push_back(s);
    mr_q.push_back(1'b1);
  endtask

  // Runs one instruction: fw fetch waits, mw memory waits, zmode 0/1 forces ZF and 2 randomizes it.
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw, input int zmode, input bit rst_wait);
    int s;
    bit exp_pcw;
    st_q.delete();
    mr_q.delete();
    push_wait(0, fw);
    push(1);
    case (opc)
      OP_LW:   begin push(2); push_wait(3, mw); push(4); end
      OP_SW:   begin push(2); push_wait(5, mw); end
      OP_R:    begin push(6); push(7); end
      OP_ADDI: begin push(8); push(9); end
      OP_BEQ:  push(10);
      OP_J:    push(11);
      default: ;
    endcase
    instr_m++;
    stall_m += fw + ((opc == OP_LW || opc == OP_SW) ? mw : 0);
    for (int i = 0; i < st_q.size(); i++) begin
      s = st_q[i];
      mem_ready = mr_q[i];
      ZF = (zmode == 2) ? 1'($urandom) : zmode[0];
      op = (s == 1) ? opc : 6'($urandom);
      #1;
      exp_pcw = (s == 0 && mr_q[i]) || (s == 10 && ZF) || (s == 11);
      chk("state", 32'(state), 32'(s));
      chk("ctrl", 32'(moore), 32'(exp_moore(s)));
      chk("PCWrite", 32'(PCWrite), 32'(exp_pcw));
      chk("IRWrite", 32'(IRWrite), 32'(s == 0 && mr_q[i]));
      chk("illegal", 32'(illegal), 32'(s == 1 && !legal(opc)));
      if (rst_wait && s == 5 && !mr_q[i]) begin
        reset = 1'b1;
        #1;
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_outs", 32'(outs), 32'd0);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rel_state", 32'(state), 32'd0);
        chk("rel_ctrl", 32'(moore), 32'(exp_moore(0)));
        @(posedge clk); #1;
        chk("rel_fetch", 32'(state), 32'd0);
        chk("rel_nowrite", 32'({MemToWrite, RegWrite, PCWrite}), 32'd0);
        instr_m = 0;
        stall_m = 1;
        return;
      end
      @(posedge clk); #1;
    end
`ifdef PERF_CNT_EN
    chk("instr_cnt", instr_cnt, 32'(instr_m));
    chk("stall_cnt", stall_cnt, 32'(stall_m));
`endif
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] rop;
    int r;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    reset = 1'b1; mem_ready = 1'b0; ZF = 1'b0; op = 6'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(outs), 32'd0);
    reset = 1'b0;

    // j, addi, sw with three stall cycles in total
    run_instr(OP_J, 1, 0, 2, 0);
    run_instr(OP_ADDI, 0, 0, 2, 0);
    run_instr(OP_SW, 0, 2, 2, 0);
`ifdef PERF_CNT_EN
    chk("perf_instr3", instr_cnt, 32'd3);
    chk("perf_stall3", stall_cnt, 32'd3);
`endif

    run_instr(OP_R, 0, 0, 2, 0);
    run_instr(OP_LW, 0, 2, 2, 0);
    run_instr(OP_BEQ, 0, 0, 1, 0);
    run_instr(OP_BEQ, 0, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 2, 0);
    run_instr(OP_SW, 1, 3, 2, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 6);
      rop = (r == 6) ? 6'($urandom) : ops[r];
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 2, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
